// File: rtl/usb_report_aggregator.sv
// usb_report_aggregator
// Gathers HID reports from C_channels host instances into a packed display
// register. Tracks per-channel liveness with a timeout and flags report
// changes. Each changed report is serialised LSB byte first over a
// valid/ready byte stream, with the channel picked round-robin.
// Optional build macro USB_REPORT_HEADER_EN puts a {4'hA, channel} header
// byte in front of every packet.
// Single clock domain (clk); synchronous active-high reset.
module usb_report_aggregator #(
  parameter int C_channels         = 3,
  parameter int C_report_bytes     = 20,
  parameter int C_capture_bytes    = 8,
  parameter int C_timeout_cycles   = 6000000,
  parameter int C_clear_on_timeout = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [C_channels*C_report_bytes*8-1:0]  hid_report,
  input  logic [C_channels-1:0]                 hid_valid,
  output logic [C_channels*C_capture_bytes*8-1:0] disp,
  output logic [C_channels-1:0]                 alive,
  output logic [C_channels-1:0]                 changed,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [7:0]                            out_byte,
  output logic                                  out_last,
  output logic [3:0]                            out_channel
);

  localparam int REP_W = C_report_bytes * 8;
  localparam int CAP_W = C_capture_bytes * 8;
  localparam int CH_W  = (C_channels > 1) ? $clog2(C_channels) : 1;
  localparam int CNT_W = $clog2(C_timeout_cycles);

`ifdef USB_REPORT_HEADER_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif

  localparam int PKT_LEN = C_capture_bytes + HDR_BYTES;
  localparam int IDX_W   = $clog2(C_capture_bytes + 1);
  // One spare zero byte on top keeps the shift slice legal for any length.
  localparam int BUF_W   = (PKT_LEN + 1) * 8;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_timeout_cycles - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(C_channels - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND
  } state_t;

  logic [CAP_W-1:0] slot     [C_channels];
  logic [CAP_W-1:0] cap_data [C_channels];
  logic [CNT_W-1:0] tmo_cnt  [C_channels];
  logic [C_channels-1:0] pending;
  logic [C_channels-1:0] pend_clr;

  state_t           state;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  sel;
  logic [CH_W-1:0]  pick;
  logic             pick_found;
  logic [CH_W:0]    cand_sum;
  logic [CH_W-1:0]  cand_idx;
  logic [BUF_W-1:0] pkt_buf;
  logic [IDX_W-1:0] byte_idx;

  // Report bytes above the capture window are intentionally ignored.
  logic unused_report_bits;
  assign unused_report_bits = ^hid_report;

  for (genvar g = 0; g < C_channels; g++) begin : g_slot
    assign cap_data[g]             = hid_report[g*REP_W +: CAP_W];
    assign disp[g*CAP_W +: CAP_W] = slot[g];
  end

  assign out_byte = pkt_buf[7:0];

  // Capture, liveness timeout, change detection and pending flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: slot is a small flop array, not a RAM; it is reset because disp
      // is required to read zero out of reset.
      for (int i = 0; i < C_channels; i++) begin
        slot[i]    <= '0;
        tmo_cnt[i] <= '0;
      end
      alive   <= '0;
      changed <= '0;
      pending <= '0;
    end else begin
      for (int i = 0; i < C_channels; i++) begin
        changed[i] <= 1'b0;
        // NOTE: non-blocking updates all sample pre-edge values, and the last
        // assignment wins, so a new change below overrides this LOAD clear.
        if (pend_clr[i]) begin
          pending[i] <= 1'b0;
        end
        if (hid_valid[i]) begin
          // A fresh report always wins over a coincident timeout expiry.
          slot[i]    <= cap_data[i];
          alive[i]   <= 1'b1;
          tmo_cnt[i] <= '0;
          if ((cap_data[i] != slot[i]) || !alive[i]) begin
            changed[i] <= 1'b1;
            pending[i] <= 1'b1;
          end
        end else if (alive[i]) begin
          if (tmo_cnt[i] == CNT_LAST) begin
            alive[i]   <= 1'b0;
            tmo_cnt[i] <= '0;
            if (C_clear_on_timeout != 0) begin
              slot[i] <= '0;
            end
          end else begin
            tmo_cnt[i] <= tmo_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Round-robin pick: first pending channel at or above rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before the loop, so no latch is
    // inferred when no channel is pending.
    pick       = rr_ptr;
    pick_found = 1'b0;
    cand_sum   = '0;
    cand_idx   = '0;
    for (int k = 0; k < C_channels; k++) begin
      cand_sum = {1'b0, rr_ptr} + (CH_W+1)'(k);
      if (cand_sum >= (CH_W+1)'(C_channels)) begin
        cand_sum = cand_sum - (CH_W+1)'(C_channels);
      end
      cand_idx = cand_sum[CH_W-1:0];
      if (!pick_found && pending[cand_idx]) begin
        pick_found = 1'b1;
        pick       = cand_idx;
      end
    end
  end

  // The pending flag of the channel being snapshotted drops during LOAD.
  always_comb begin
    pend_clr = '0;
    if (state == ST_LOAD) begin
      pend_clr[sel] = 1'b1;
    end
  end

  // Stream FSM: IDLE -> LOAD (snapshot) -> SEND (one byte per handshake).
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      sel         <= '0;
      pkt_buf     <= '0;
      byte_idx    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_channel <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            sel   <= pick;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // The snapshot decouples the packet in flight from new reports.
`ifdef USB_REPORT_HEADER_EN
          pkt_buf <= {8'h00, slot[sel], 4'hA, 4'(sel)};
`else
          pkt_buf <= {8'h00, slot[sel]};
`endif
          byte_idx    <= '0;
          out_channel <= 4'(sel);
          out_last    <= (PKT_LEN == 1);
          out_valid   <= 1'b1;
          rr_ptr      <= (sel == CH_LAST) ? '0 : sel + 1'b1;
          state       <= ST_SEND;
        end
        ST_SEND: begin
          // Everything holds while the consumer stalls.
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              pkt_buf  <= {8'h00, pkt_buf[BUF_W-1:8]};
              byte_idx <= byte_idx + 1'b1;
              out_last <= ((byte_idx + 1'b1) == IDX_LAST);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_report_aggregator.sv
// Self-checking bench for usb_report_aggregator: table-driven capture rows,
// directed corner sequences and randomized batches checked against a
// deadline-based reference model. Honors USB_REPORT_HEADER_EN.
module tb_usb_report_aggregator;

  localparam int CH    = 3;
  localparam int RB    = 20;
  localparam int CB    = 8;
  localparam int TMO   = 100;
  localparam int CAP_W = CB * 8;
  localparam int REP_W = RB * 8;
`ifdef USB_REPORT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int PLEN = CB + HDR;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [CH*REP_W-1:0]   hid_report;
  logic [CH-1:0]         hid_valid;
  logic [CH*CAP_W-1:0]   disp;
  logic [CH-1:0]         alive;
  logic [CH-1:0]         changed;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_byte;
  logic                  out_last;
  logic [3:0]            out_channel;

  always #5 clk = ~clk;

  usb_report_aggregator #(
    .C_channels(CH),
    .C_report_bytes(RB),
    .C_capture_bytes(CB),
    .C_timeout_cycles(TMO),
    .C_clear_on_timeout(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hid_report(hid_report),
    .hid_valid(hid_valid),
    .disp(disp),
    .alive(alive),
    .changed(changed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_byte(out_byte),
    .out_last(out_last),
    .out_channel(out_channel)
  );

  typedef struct {
    int               ch;
    logic [CAP_W-1:0] data;
    int               len;
    logic [7:0]       hdr;
  } pkt_t;

  typedef struct {
    logic [CAP_W-1:0] data;
    bit               exp_chg;
    int               exp_pkts;
  } vec_t;

  pkt_t rx_q[$];
  int   gaps_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  logic [CAP_W-1:0] m_slot [CH];
  bit               m_alive[CH];
  longint           m_last [CH];
  bit [CH-1:0]      m_chg;
  int               m_rr;
  longint           cyc = 0;

  // Packet assembly
  int               rx_cnt = 0;
  int               rx_ch = 0;
  logic [CAP_W-1:0] rx_data = '0;
  logic [7:0]       rx_hdr = '0;
  int               idle_run = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [CAP_W-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_slot[i]  = '0;
      m_alive[i] = 1'b0;
      m_last[i]  = 0;
    end
    m_chg    = '0;
    m_rr     = 0;
    rx_cnt   = 0;
    rx_data  = '0;
    idle_run = 0;
  endtask

  task automatic set_report(input int ch, input logic [CAP_W-1:0] d);
    hid_report[ch*REP_W +: CAP_W] = d;
    for (int b = CAP_W; b < REP_W; b++) hid_report[ch*REP_W + b] = 1'($urandom_range(0, 1));
    hid_valid[ch] = 1'b1;
  endtask

  // One clock: apply current inputs, update the model, check outputs.
  task automatic tick();
    bit               hs, p_valid, p_ready, rst_now;
    logic [7:0]       p_byte;
    logic             p_last;
    logic [3:0]       p_ch;
    logic [CAP_W-1:0] d;
    logic [CH*CAP_W-1:0] e_disp;
    logic [CH-1:0]    e_alive;
    p_valid = (out_valid === 1'b1);
    p_ready = out_ready;
    hs      = p_valid && p_ready;
    p_byte  = out_byte;
    p_last  = out_last;
    p_ch    = out_channel;
    rst_now = reset;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_now) begin
      model_reset();
    end else begin
      if (hs) begin
        if (rx_cnt == 0) rx_ch = int'(p_ch);
        else check("pkt_channel_steady", p_ch, rx_ch);
        if (rx_cnt < HDR) rx_hdr = p_byte;
        else if (rx_cnt - HDR < CB) rx_data[(rx_cnt-HDR)*8 +: 8] = p_byte;
        rx_cnt++;
        if (p_last) begin
          rx_q.push_back('{ch: rx_ch, data: rx_data, len: rx_cnt, hdr: rx_hdr});
          m_rr    = (rx_ch + 1) % CH;
          rx_cnt  = 0;
          rx_data = '0;
        end
      end
      for (int i = 0; i < CH; i++) begin
        m_chg[i] = 1'b0;
        if (hid_valid[i]) begin
          d = hid_report[i*REP_W +: CAP_W];
          if ((d !== m_slot[i]) || !m_alive[i]) m_chg[i] = 1'b1;
          m_slot[i]  = d;
          m_alive[i] = 1'b1;
          m_last[i]  = cyc;
        end else if (m_alive[i] && (cyc - m_last[i] >= TMO)) begin
          m_alive[i] = 1'b0;
          m_slot[i]  = '0;
        end
      end
      if (out_valid === 1'b1) begin
        if (!p_valid) gaps_q.push_back(idle_run);
        idle_run = 0;
      end else begin
        idle_run++;
      end
    end
    for (int i = 0; i < CH; i++) begin
      e_disp[i*CAP_W +: CAP_W] = m_slot[i];
      e_alive[i] = m_alive[i];
    end
    check("disp", disp, e_disp);
    check("alive", alive, e_alive);
    check("changed", changed, m_chg);
    if (p_valid && !p_ready && !rst_now) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_byte", out_byte, p_byte);
      check("stall_last", out_last, p_last);
      check("stall_channel", out_channel, p_ch);
    end
    hid_valid = '0;
    reset     = 1'b0;
  endtask

  // Run the stream until n_exp packets arrived (bounded), then settle.
  task automatic drain(input int n_exp, input int mode);
    int budget;
    budget = 400;
    while (rx_q.size() < n_exp && budget > 0) begin
      out_ready = (mode == 0 || cyc % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      budget--;
    end
    out_ready = 1'b1;
    repeat (8) tick();
    check("packet_count", rx_q.size(), n_exp);
    check("drain_idle", out_valid, 1'b0);
  endtask

  task automatic wait_valid();
    int b;
    b = 0;
    out_ready = 1'b0;
    while (out_valid !== 1'b1 && b < 20) begin
      tick();
      b++;
    end
    check("wait_valid", out_valid, 1'b1);
  endtask

  task automatic check_pkt(input int idx, input int ch, input logic [CAP_W-1:0] data);
    pkt_t p;
    if (idx >= rx_q.size()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pkt%0d: got no packet, expected channel %0d data %0h", idx, ch, data);
      return;
    end
    p = rx_q[idx];
    check($sformatf("pkt%0d_channel", idx), p.ch, ch);
    check($sformatf("pkt%0d_data", idx), p.data, data);
    check($sformatf("pkt%0d_len", idx), p.len, PLEN);
`ifdef USB_REPORT_HEADER_EN
    check($sformatf("pkt%0d_header", idx), p.hdr, {4'hA, 4'(ch)});
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t             vt[6];
    logic [CAP_W-1:0] d [CH];
    logic [CAP_W-1:0] exp_d [CH];
    int               exp_q[$];
    int               n, rr0, vcount, c;

    vt[0] = '{64'h0807060504030201, 1'b1, 1};
    vt[1] = '{64'h0807060504030201, 1'b0, 0};
    vt[2] = '{64'h0807060504030255, 1'b1, 1};
    vt[3] = '{64'h0807060504030255, 1'b0, 0};
    vt[4] = '{64'h0000000000000000, 1'b1, 1};
    vt[5] = '{64'h0000000000000000, 1'b0, 0};

    hid_report = '0;
    hid_valid  = '0;
    out_ready  = 1'b1;
    model_reset();

    // Reset state
    reset = 1'b1; tick();
    reset = 1'b1; tick();
    check("rst_disp", disp, 0);
    check("rst_alive", alive, 0);
    check("rst_changed", changed, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_byte", out_byte, 0);
    check("rst_out_channel", out_channel, 0);

    // Table: capture / change detection on channel 1
    for (int k = 0; k < 6; k++) begin
      rx_q.delete();
      set_report(1, vt[k].data);
      tick();
      check($sformatf("tbl%0d_changed", k), changed, vt[k].exp_chg ? 3'b010 : 3'b000);
      check($sformatf("tbl%0d_slot1", k), disp[CAP_W +: CAP_W], vt[k].data);
      check($sformatf("tbl%0d_alive", k), alive, 3'b010);
      drain(vt[k].exp_pkts, k % 2);
      if (vt[k].exp_pkts != 0) check_pkt(0, 1, vt[k].data);
    end

    // Move rr pointer to 0 with a channel 2 packet, then triple -> 0,1,2
    rx_q.delete();
    d[2] = rnd_data();
    set_report(2, d[2]); tick(); drain(1, 0);
    check_pkt(0, 2, d[2]);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        rx_q.delete();
        d[1] = ~m_slot[1];
        set_report(1, d[1]); tick(); drain(1, 0);
        check_pkt(0, 1, d[1]);
      end
      rx_q.delete();
      gaps_q.delete();
      for (int i = 0; i < CH; i++) begin
        d[i] = rnd_data();
        if (d[i] == m_slot[i]) d[i] = ~d[i];
        set_report(i, d[i]);
      end
      tick();
      check($sformatf("triple%0d_changed", pass), changed, 3'b111);
      drain(3, 0);
      for (int i = 0; i < 3; i++) begin
        c = (pass == 0) ? i : (i + 2) % 3;
        check_pkt(i, c, d[c]);
      end
      check($sformatf("triple%0d_gap_count", pass), gaps_q.size(), 3);
      for (int i = 1; i < gaps_q.size(); i++)
        check($sformatf("triple%0d_gap%0d", pass, i), gaps_q[i], 2);
    end

    // Stalls 1,0,0,1,... with a new report on the same channel mid-packet
    rx_q.delete();
    d[0] = ~m_slot[1];
    d[1] = rnd_data();
    if (d[1] == d[0]) d[1] = ~d[1];
    set_report(1, d[0]); tick();
    wait_valid();
    for (int k = 0; k < 16; k++) begin
      out_ready = (k % 8 == 0 || k % 8 == 3 || k % 8 == 5) ? 1'b1 : 1'b0;
      if (k == 4) set_report(1, d[1]);
      tick();
    end
    drain(2, 1);
    check_pkt(0, 1, d[0]);
    check_pkt(1, 1, d[1]);

    // Timeout: all channels die, then a single report expires after TMO
    out_ready = 1'b1;
    repeat (TMO + 20) tick();
    check("all_dead", alive, 0);
    rx_q.delete();
    d[0] = rnd_data() | 64'h1;
    set_report(0, d[0]); tick();
    n = 0;
    while (alive[0] === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("alive_drop_cycles", n, TMO);
    check("slot0_cleared", disp[0 +: CAP_W], 0);
    check("timeout_no_packet", rx_q.size(), 1);

    // Report coincident with expiry keeps the channel alive
    set_report(0, d[0]); tick();
    repeat (TMO - 1) tick();
    set_report(0, d[0]); tick();
    check("coincident_alive", alive[0], 1'b1);
    check("coincident_no_change", changed[0], 1'b0);

    // After death an identical report is a change again
    repeat (TMO + 10) tick();
    check("dead_again", alive[0], 1'b0);
    rx_q.delete();
    set_report(0, d[0]); tick();
    check("revive_changed", changed, 3'b001);
    drain(1, 0);
    check_pkt(0, 0, d[0]);

    // Reset during byte 3 aborts the packet and drops all pending work
    for (int i = 0; i < CH; i++) begin
      d[i] = rnd_data();
      if (d[i] == m_slot[i]) d[i] = ~d[i];
      set_report(i, d[i]);
    end
    tick();
    wait_valid();
    out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b1; tick();
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_disp", disp, 0);
    rx_q.delete();
    vcount = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (out_valid === 1'b1) vcount++;
    end
    check("midrst_quiet", vcount, 0);
    check("midrst_no_packets", rx_q.size(), 0);
    d[0] = rnd_data();
    set_report(0, d[0]); tick();
    drain(1, 0);
    check_pkt(0, 0, d[0]);

    // Randomized batches against the model
    for (int b = 0; b < 40; b++) begin
      rx_q.delete();
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          set_report(i, ($urandom_range(0, 1) == 1) ? m_slot[i] : rnd_data());
        end
      end
      rr0 = m_rr;
      tick();
      exp_q.delete();
      for (int k = 0; k < CH; k++) begin
        c = (rr0 + k) % CH;
        if (m_chg[c]) begin
          exp_q.push_back(c);
          exp_d[c] = m_slot[c];
        end
      end
      drain(exp_q.size(), 1);
      for (int i = 0; i < exp_q.size(); i++) check_pkt(i, exp_q[i], exp_d[exp_q[i]]);
      n = $urandom_range(0, 130);
      repeat (n) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/usb_report_aggregator.md
Name: usb_report_aggregator

Overview:
- Collects HID reports from C_channels usb_host_hid instances and maintains a packed display register for the hex decoder and LCD/DVI paths.
- Tracks per-channel liveness with a timeout and detects report changes.
- Serialises each changed report as a byte packet over a valid/ready stream, for UART or SPI debug dump.
- Everything runs in the USB clock domain: 6 MHz for low-speed, 48 MHz for full-speed.

Parameters:
- C_channels, 3: number of HID host inputs (1..16).
- C_report_bytes, 20: width in bytes of each hid_report input.
- C_capture_bytes, 8: low-order bytes captured per channel (1..C_report_bytes).
- C_timeout_cycles, 6000000: clk cycles without hid_valid before a channel is declared dead (1 s at 6 MHz; minimum 2).
- C_clear_on_timeout, 1: when 1, zero a channel's display slot when it times out.

Ports:
- clk  in  1  USB clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- hid_report  in  C_channels*C_report_bytes*8  concatenated reports; channel i occupies bits [(i+1)*C_report_bytes*8-1 : i*C_report_bytes*8].
- hid_valid  in  C_channels  one-cycle pulse per channel when its report is valid.
- disp  out  C_channels*C_capture_bytes*8  display register; slot i is [(i+1)*C_capture_bytes*8-1 : i*C_capture_bytes*8].
- alive  out  C_channels  channel has reported within the timeout window.
- changed  out  C_channels  one-cycle pulse: captured data differs from the previous value, or is the first report after dead/reset.
- out_valid  out  1  stream byte valid.
- out_ready  in  1  stream consumer ready.
- out_byte  out  8  stream data.
- out_last  out  1  final byte of the packet.
- out_channel  out  4  channel index of the current packet.

Behaviour:
- Reset values:
  - disp=0, alive=0, changed=0, out_valid=0, out_last=0, out_byte=0, out_channel=0.
  - All timeout counters and pending flags cleared; FSM in IDLE; round-robin pointer=0.
  - Reset asserted mid-packet aborts the packet with no further bytes; the consumer sees out_valid=0 on the cycle after the reset edge.
- Capture:
  - hid_valid[i] at edge N updates slot i with report bytes [C_capture_bytes-1:0] at edge N (visible cycle N+1).
  - The same edge sets alive[i]=1 and zeroes counter i.
  - changed[i] pulses in cycle N+1 iff the new bytes differ from the old slot, or alive[i] was 0. The same condition sets pending[i].
  - Identical repeated reports: no pulse, no packet.
- Timeout:
  - counter i increments each cycle while alive[i] and no hid_valid[i].
  - When counter i reaches C_timeout_cycles-1, alive[i]->0 on the next edge. If C_clear_on_timeout=1, slot i->0 on that same edge.
  - Timeout does not generate a packet or a changed pulse.
  - hid_valid[i] coincident with timeout expiry: valid wins, and the channel stays alive.
- Stream FSM:
  - IDLE: if any pending, pick the lowest index at or above the rr pointer (wrapping), then go to LOAD. Otherwise stay in IDLE.
  - LOAD (1 cycle): snapshot slot into the packet buffer, clear pending[sel], set out_channel=sel, rr pointer=sel+1 mod C_channels, then go to SEND.
  - SEND: out_valid=1. out_byte = buffer byte k, with k from 0 (LSB byte first) to C_capture_bytes-1. out_last=1 when k is the final index. The byte advances only on the edge where out_valid and out_ready are both high. A handshake on the last byte goes to IDLE.
  - out_byte, out_last and out_channel are held stable while out_valid=1 and out_ready=0. out_valid never drops without a handshake, except on reset.
  - A new report on the sending channel during SEND re-sets pending. The packet in flight uses the snapshot and is not altered.
  - Minimum gap: 2 idle cycles between packets (IDLE + LOAD).
  - Channel select and pointer arithmetic are modulo C_channels. The byte index width is clog2(C_capture_bytes+1).

Optional Feature:
- Macro: USB_REPORT_HEADER_EN.
- Defined: each packet starts with a header byte {4'hA, out_channel}, followed by C_capture_bytes data bytes. out_last is on data byte C_capture_bytes-1, and the packet length is C_capture_bytes+1.
- Undefined: no header, and the packet length is C_capture_bytes.

Test Plan:
- reset, then hid_valid[1] with report bytes 0x01..0x08 (C_capture_bytes=8) -> disp slot1=0x0807060504030201 next cycle, changed=3'b010, alive=3'b010; packet on out_channel=1 of 01,02,..,08 with out_last on 08 (header 0xA1 first if the macro is defined).
- Same report repeated on channel 1 -> changed stays 0, no packet. Then byte0 changed to 0x55 -> one pulse, one packet starting 0x55.
- hid_valid on channels 0,1,2 in the same cycle, with out_ready=1 -> three packets in order 0,1,2. Repeat with the rr pointer at 2 -> order 2,0,1.
- out_ready toggling 1,0,0,1 during a packet -> out_byte and out_last held across stalls; no bytes lost or duplicated; a new report mid-packet yields a second packet afterwards.
- C_timeout_cycles=100: one report then silence -> alive[i] drops exactly 100 cycles after the valid edge and slot i=0. A valid pulse on cycle 99 keeps the channel alive. After death, resending an identical report -> changed pulse and packet.
- Assert reset during byte 3 of a packet -> out_valid=0 the next cycle, pending=0, disp=0, and nothing is emitted until a new hid_valid.
